universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range is 2..32.
- REQ-002: The block SHALL have parameter RESET_VAL, default 0, WIDTH bits, giving the register contents after reset and after the clear mode.
- REQ-003: The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
- REQ-004: The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
- REQ-005: The block SHALL have port en, input, 1 bit, operation enable; when low, all state holds.
- REQ-006: The block SHALL have port mode, input, 3 bits, operation select as defined in REQ-013.
- REQ-007: The block SHALL have port ser_in_l, input, 1 bit, the bit entering bit 0 on a left shift.
- REQ-008: The block SHALL have port ser_in_r, input, 1 bit, the bit entering bit WIDTH-1 on a right shift.
- REQ-009: The block SHALL have port par_in, input, WIDTH bits, parallel load data.
- REQ-010: The block SHALL have port par_out, output, WIDTH bits, current register contents.
- REQ-011: The block SHALL have ports ser_out_msb and ser_out_lsb, outputs, 1 bit each, equal to par_out[WIDTH-1] and par_out[0] respectively.
- REQ-012: The block SHALL have ports frame_done, output, 1 bit (registered one-cycle pulse), and shift_cnt, output, max(1,$clog2(WIDTH)) bits (shifts since last frame boundary).

Function
- REQ-013: mode encoding SHALL apply only when en=1 and rst=0:
  - 000: hold.
  - 001: shift left, {r[W-2:0], ser_in_l}.
  - 010: shift right, {ser_in_r, r[W-1:1]}.
  - 011: rotate left, {r[W-2:0], r[W-1]}.
  - 100: rotate right, {r[0], r[W-1:1]}.
  - 101: parallel load, r <= par_in.
  - 110: clear, r <= RESET_VAL.
  - 111: reserved, treated as hold.
- REQ-014: The register update SHALL take effect on the clock edge at which the mode is sampled, so par_out and ser_out_* show the result one cycle after the input (latency 1).
- REQ-015: ser_out_msb and ser_out_lsb SHALL be combinational taps of the register, with no extra delay.
- REQ-016: Modes 001-100 SHALL each be a "shift op"; each shift op SHALL increment shift_cnt by 1.
- REQ-017: When a shift op occurs with shift_cnt = WIDTH-1, shift_cnt SHALL wrap to 0 and frame_done SHALL be 1 in the following cycle only.
- REQ-018: Parallel load and clear SHALL set shift_cnt to 0 and SHALL NOT assert frame_done.
- REQ-019: Hold, reserved mode, and en=0 SHALL leave the register and shift_cnt unchanged and drive frame_done to 0 next cycle.
- REQ-020: Back-to-back frames SHALL be supported: 2*WIDTH consecutive shift ops SHALL produce exactly two frame_done pulses, WIDTH cycles apart.
- REQ-021: Mode changes between shift directions mid-frame SHALL NOT reset shift_cnt.

Reset
- REQ-022: While rst=1 at a clock edge, the register SHALL become RESET_VAL, shift_cnt 0, and frame_done 0, regardless of en and mode.
- REQ-023: rst SHALL take priority over every mode, including mid-frame; the first operation after rst deasserts SHALL count from shift_cnt=0.
- REQ-024: Outputs SHALL be undefined only before the first clock edge with rst=1; no asynchronous behaviour SHALL exist.

Verification (WIDTH=4, RESET_VAL=0 unless stated)
- REQ-025: Reset then load: rst 1 cycle, then mode=101, par_in=1011 -> par_out=1011 next cycle, shift_cnt=0, frame_done=0.
- REQ-026: Serial fill: from 0000, four mode=001 cycles with ser_in_l=1,0,1,1 -> par_out=1011, ser_out_msb=1; frame_done=1 exactly in the cycle after the 4th shift; shift_cnt=0.
- REQ-027: Rotate: load 1000, then mode=100 for four cycles -> par_out sequence 0100, 0010, 0001, 1000 with one frame_done pulse; then mode=011 once -> 0001.
- REQ-028: Right shift with en gaps: load 1111, then mode=010 with ser_in_r=0, en toggling 1,0,1 -> par_out 0111, 0111, 0011; shift_cnt 1, 1, 2.
- REQ-029: Reset mid-frame: two shift ops, then rst=1 with mode=001 and en=1 -> par_out=0000, shift_cnt=0; four further shifts give frame_done after the 4th, not earlier.
- REQ-030: Clear/reserved/parameter: with RESET_VAL=1010, mode=110 -> 1010, shift_cnt=0; mode=111 -> unchanged; repeat REQ-026 at WIDTH=8 and WIDTH=2 and check frame_done period equals WIDTH.

Source files
------------

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_reg
//  Purpose  : WIDTH-bit universal shift register with shift/rotate in both
//             directions, parallel load and clear, plus a frame counter
//             that pulses frame_done after every WIDTH shift operations.
//  Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic [2:0]                                mode,
  input  logic                                      ser_in_l,
  input  logic                                      ser_in_r,
  input  logic [WIDTH-1:0]                          par_in,
  output logic [WIDTH-1:0]                          par_out,
  output logic                                      ser_out_msb,
  output logic                                      ser_out_lsb,
  output logic                                      frame_done,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] shift_cnt
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  // Next-state decode: data path by mode, then frame counter for shift ops.
  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHL: begin
          data_d   = {data_q[WIDTH-2:0], ser_in_l};
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          data_d   = {ser_in_r, data_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          data_d   = {data_q[0], data_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          data_d = par_in;
          cnt_d  = '0;
        end
        MODE_CLR: begin
          data_d = RESET_VAL;
          cnt_d  = '0;
        end
        // MODE_HOLD and the reserved code keep everything as is.
        default: ;
      endcase
    end
    // Direction changes mid-frame keep counting; only load/clear/reset restart it.
    if (shift_op) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous reset taking priority over every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign par_out     = data_q;
  assign ser_out_msb = data_q[WIDTH-1];
  assign ser_out_lsb = data_q[0];
  assign frame_done  = done_q;
  assign shift_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_shift_reg
//  Purpose  : Scoreboard bench for universal_shift_reg. Four instances cover
//             WIDTH=4 (RESET_VAL 0 and 1010), WIDTH=8 and WIDTH=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;

  typedef struct {
    int          id;
    logic [31:0] par;
    int          cnt;
    logic        done;
    logic        msb;
    logic        lsb;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v  [4];
  logic        en_v   [4];
  logic [2:0]  mode_v [4];
  logic        sl_v   [4];
  logic        sr_v   [4];
  logic [31:0] par_v  [4];

  logic [3:0]  po0, po1;
  logic [7:0]  po2;
  logic [1:0]  po3;
  logic [1:0]  sc0, sc1;
  logic [2:0]  sc2;
  logic        sc3;
  logic        msb_v  [4];
  logic        lsb_v  [4];
  logic        done_v [4];

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   WID[4] = '{4, 4, 8, 2};

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) u_w4 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .mode(mode_v[0]),
    .ser_in_l(sl_v[0]), .ser_in_r(sr_v[0]), .par_in(par_v[0][3:0]),
    .par_out(po0), .ser_out_msb(msb_v[0]), .ser_out_lsb(lsb_v[0]),
    .frame_done(done_v[0]), .shift_cnt(sc0));

  universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'b1010)) u_w4c (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .mode(mode_v[1]),
    .ser_in_l(sl_v[1]), .ser_in_r(sr_v[1]), .par_in(par_v[1][3:0]),
    .par_out(po1), .ser_out_msb(msb_v[1]), .ser_out_lsb(lsb_v[1]),
    .frame_done(done_v[1]), .shift_cnt(sc1));

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_w8 (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .mode(mode_v[2]),
    .ser_in_l(sl_v[2]), .ser_in_r(sr_v[2]), .par_in(par_v[2][7:0]),
    .par_out(po2), .ser_out_msb(msb_v[2]), .ser_out_lsb(lsb_v[2]),
    .frame_done(done_v[2]), .shift_cnt(sc2));

  universal_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) u_w2 (
    .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .mode(mode_v[3]),
    .ser_in_l(sl_v[3]), .ser_in_r(sr_v[3]), .par_in(par_v[3][1:0]),
    .par_out(po3), .ser_out_msb(msb_v[3]), .ser_out_lsb(lsb_v[3]),
    .frame_done(done_v[3]), .shift_cnt(sc3));

  function automatic void check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endfunction

  // Apply one cycle of stimulus to instance id and queue its expected result.
  task automatic drive(input int id, input logic r, input logic e, input logic [2:0] m,
                       input logic sl, input logic sr, input logic [31:0] p,
                       input logic [31:0] ep, input int ec, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rst_v[k] = 1'b0;
      en_v[k]  = 1'b0;
    end
    rst_v[id] = r;  en_v[id] = e;  mode_v[id] = m;
    sl_v[id]  = sl; sr_v[id] = sr; par_v[id]  = p;
    x.id = id; x.par = ep; x.cnt = ec; x.done = ed;
    x.msb = ep[WID[id]-1]; x.lsb = ep[0]; x.nm = nm;
    sb.push_back(x);
  endtask

  // Reset, then 2*w left shifts with the 1,0,1,1 pattern; done every w shifts.
  task automatic frame_run(input int id, input int w, input int n, input string nm);
    logic [31:0] mdl;
    logic [31:0] mask;
    bit          pat[4];
    int          c;
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1};
    mdl  = '0;
    c    = 0;
    mask = (32'h1 << w) - 32'h1;
    drive(id, 1, 1, 3'b001, 1, 0, 0, 0, 0, 0, {nm, "_rst"});
    for (int i = 0; i < n; i++) begin
      mdl = ((mdl << 1) | 32'(pat[i % 4])) & mask;
      c   = (c + 1) % w;
      drive(id, 0, 1, 3'b001, pat[i % 4], 0, 0, mdl, c, (c == 0), nm);
    end
  endtask

  // Monitor: every cycle holds one result; pop and compare just after the edge.
  initial begin
    exp_t x;
    int   ap, ac, ad, am, al;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.id)
          0:       begin ap = int'(po0); ac = int'(sc0); end
          1:       begin ap = int'(po1); ac = int'(sc1); end
          2:       begin ap = int'(po2); ac = int'(sc2); end
          default: begin ap = int'(po3); ac = int'(sc3); end
        endcase
        ad = int'(done_v[x.id]);
        am = int'(msb_v[x.id]);
        al = int'(lsb_v[x.id]);
        check({x.nm, "/par_out"},     ap, int'(x.par));
        check({x.nm, "/shift_cnt"},   ac, x.cnt);
        check({x.nm, "/frame_done"},  ad, int'(x.done));
        check({x.nm, "/ser_out_msb"}, am, int'(x.msb));
        check({x.nm, "/ser_out_lsb"}, al, int'(x.lsb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_v[k] = 1'b1; en_v[k] = 1'b0; mode_v[k] = 3'b000;
      sl_v[k] = 1'b0;  sr_v[k] = 1'b0; par_v[k] = '0;
    end

    // WIDTH=4, RESET_VAL=0: reset then load
    drive(0, 1, 1, 3'b101, 0, 0, 4'b1111, 4'b0000, 0, 0, "reset");
    drive(0, 0, 1, 3'b101, 0, 0, 4'b1011, 4'b1011, 0, 0, "load");
    // serial fill
    drive(0, 0, 1, 3'b110, 0, 0, 0, 4'b0000, 0, 0, "clr0");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0001, 1, 0, "fill1");
    drive(0, 0, 1, 3'b001, 0, 0, 0, 4'b0010, 2, 0, "fill2");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0101, 3, 0, "fill3");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b1011, 0, 1, "fill4");
    drive(0, 0, 1, 3'b000, 0, 0, 0, 4'b1011, 0, 0, "hold");
    // rotate right x4 then rotate left
    drive(0, 0, 1, 3'b101, 0, 0, 4'b1000, 4'b1000, 0, 0, "ld1000");
    drive(0, 0, 1, 3'b100, 0, 0, 0, 4'b0100, 1, 0, "ror1");
    drive(0, 0, 1, 3'b100, 0, 0, 0, 4'b0010, 2, 0, "ror2");
    drive(0, 0, 1, 3'b100, 0, 0, 0, 4'b0001, 3, 0, "ror3");
    drive(0, 0, 1, 3'b100, 0, 0, 0, 4'b1000, 0, 1, "ror4");
    drive(0, 0, 1, 3'b011, 0, 0, 0, 4'b0001, 1, 0, "rol");
    // right shift with an enable gap
    drive(0, 0, 1, 3'b101, 0, 0, 4'b1111, 4'b1111, 0, 0, "ld1111");
    drive(0, 0, 1, 3'b010, 0, 0, 0, 4'b0111, 1, 0, "shr_en1");
    drive(0, 0, 0, 3'b010, 0, 0, 0, 4'b0111, 1, 0, "shr_en0");
    drive(0, 0, 1, 3'b010, 0, 0, 0, 4'b0011, 2, 0, "shr_en1b");
    // reset mid-frame
    drive(0, 0, 1, 3'b101, 0, 0, 4'b0000, 4'b0000, 0, 0, "ld0000");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0001, 1, 0, "pre1");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0011, 2, 0, "pre2");
    drive(0, 1, 1, 3'b001, 1, 0, 0, 4'b0000, 0, 0, "midrst");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0001, 1, 0, "post1");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0011, 2, 0, "post2");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b0111, 3, 0, "post3");
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b1111, 0, 1, "post4");
    // mixed directions within one frame keep counting
    drive(0, 0, 1, 3'b101, 0, 0, 4'b0110, 4'b0110, 0, 0, "ld0110");
    drive(0, 0, 1, 3'b001, 0, 0, 0, 4'b1100, 1, 0, "mix_shl");
    drive(0, 0, 1, 3'b010, 0, 1, 0, 4'b1110, 2, 0, "mix_shr");
    drive(0, 0, 1, 3'b011, 0, 0, 0, 4'b1101, 3, 0, "mix_rol");
    drive(0, 0, 1, 3'b100, 0, 0, 0, 4'b1110, 0, 1, "mix_ror");
    drive(0, 0, 1, 3'b111, 0, 0, 4'b0101, 4'b1110, 0, 0, "rsvd");
    // load mid-frame restarts the count without a pulse
    drive(0, 0, 1, 3'b001, 1, 0, 0, 4'b1101, 1, 0, "pre_ld");
    drive(0, 0, 1, 3'b101, 0, 0, 4'b0101, 4'b0101, 0, 0, "ld_mid");
    // back-to-back frames at WIDTH=4
    frame_run(0, 4, 8, "w4frames");

    // WIDTH=4, RESET_VAL=1010: clear and reserved mode
    drive(1, 1, 0, 3'b000, 0, 0, 0, 4'b1010, 0, 0, "rv_reset");
    drive(1, 0, 1, 3'b101, 0, 0, 4'b0011, 4'b0011, 0, 0, "rv_load");
    drive(1, 0, 1, 3'b001, 0, 0, 0, 4'b0110, 1, 0, "rv_shl");
    drive(1, 0, 1, 3'b110, 0, 0, 0, 4'b1010, 0, 0, "rv_clr");
    drive(1, 0, 1, 3'b001, 1, 0, 0, 4'b0101, 1, 0, "rv_shl2");
    drive(1, 0, 1, 3'b111, 1, 1, 4'b1111, 4'b0101, 1, 0, "rv_rsvd");

    // WIDTH=8 and WIDTH=2: frame_done period equals WIDTH
    frame_run(2, 8, 16, "w8frames");
    frame_run(3, 2, 4,  "w2frames");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
